// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

  localparam int KEY_W = 4;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam logic [ROWS-1:0] ROWS_IDLE = 4'hF;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // Index of the lowest-numbered row pulled low; any higher low rows are ignored.
  function automatic logic [1:0] low_row(input logic [ROWS-1:0] rows);
    logic [1:0] idx;
    casez (rows)
      4'b???0: idx = 2'd0;
      4'b??01: idx = 2'd1;
      4'b?011: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_row_sync.sv
// Two-flop synchronizer for the asynchronous, pulled-up keypad rows.
module row_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Resets to all-ones so an idle keypad is seen right after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= {WIDTH{1'b1}};
      sync_r <= {WIDTH{1'b1}};
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column scan, press/release debounce and key code strobe.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 12000,
  parameter int DEBOUNCE_CNT = 240000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int DW_W = $clog2(SCAN_DIV) + 1;
  localparam int DB_W = $clog2(DEBOUNCE_CNT) + 1;
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(SCAN_DIV - 1);
  localparam logic [DW_W-1:0] DW_MAX  = {DW_W{1'b1}};
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CNT - 1);
  localparam logic [DB_W-1:0] DB_MAX  = {DB_W{1'b1}};

  logic [ROWS-1:0]  rows_s;
  state_t           state_r, state_nxt_s;
  logic [1:0]       col_r, col_nxt_s;
  logic [DW_W-1:0]  dwell_r, dwell_nxt_s;
  logic [DB_W-1:0]  db_r, db_nxt_s;
  logic [ROWS-1:0]  pat_r, pat_nxt_s;
  logic [KEY_W-1:0] code_r, code_nxt_s;
  logic             held_r, held_nxt_s;
  logic             valid_r, fire_s;
  logic [COLS-1:0]  col_out_r;

  row_sync #(.WIDTH(ROWS)) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (row_in),
    .q   (rows_s)
  );

  // Next-state, counter and output decisions, all taken from the synchronized rows.
  always_comb begin
    state_nxt_s = state_r;
    col_nxt_s   = col_r;
    dwell_nxt_s = dwell_r;
    db_nxt_s    = db_r;
    pat_nxt_s   = pat_r;
    code_nxt_s  = code_r;
    held_nxt_s  = held_r;
    fire_s      = 1'b0;
    case (state_r)
      SCAN: begin
        if (dwell_r >= DW_LAST) begin
          dwell_nxt_s = {DW_W{1'b0}};
          if (rows_s != ROWS_IDLE) begin
            pat_nxt_s   = rows_s;
            db_nxt_s    = {DB_W{1'b0}};
            state_nxt_s = DEBOUNCE;
          end else begin
            col_nxt_s = col_r + 2'd1;
          end
        end else begin
          dwell_nxt_s = (dwell_r == DW_MAX) ? dwell_r : dwell_r + DW_W'(1);
        end
      end
      DEBOUNCE: begin
        if (rows_s == pat_r) begin
          if (db_r >= DB_LAST) begin
            fire_s      = 1'b1;
            code_nxt_s  = {low_row(pat_r), col_r};
            held_nxt_s  = 1'b1;
            db_nxt_s    = {DB_W{1'b0}};
            state_nxt_s = PRESSED;
          end else begin
            db_nxt_s = (db_r == DB_MAX) ? db_r : db_r + DB_W'(1);
          end
        end else begin
          // A bounce gives up on this column and resumes the scan at the next one.
          db_nxt_s    = {DB_W{1'b0}};
          dwell_nxt_s = {DW_W{1'b0}};
          col_nxt_s   = col_r + 2'd1;
          state_nxt_s = SCAN;
        end
      end
      PRESSED: begin
        if (rows_s == ROWS_IDLE) begin
          db_nxt_s    = {DB_W{1'b0}};
          state_nxt_s = RELEASE;
        end else begin
          state_nxt_s = PRESSED;
        end
      end
      RELEASE: begin
        if (rows_s == ROWS_IDLE) begin
          if (db_r >= DB_LAST) begin
            held_nxt_s  = 1'b0;
            db_nxt_s    = {DB_W{1'b0}};
            dwell_nxt_s = {DW_W{1'b0}};
            col_nxt_s   = 2'd0;
            state_nxt_s = SCAN;
          end else begin
            db_nxt_s = (db_r == DB_MAX) ? db_r : db_r + DB_W'(1);
          end
        end else begin
          db_nxt_s    = {DB_W{1'b0}};
          state_nxt_s = PRESSED;
        end
      end
      default: begin
        state_nxt_s = SCAN;
        col_nxt_s   = 2'd0;
        dwell_nxt_s = {DW_W{1'b0}};
        db_nxt_s    = {DB_W{1'b0}};
        held_nxt_s  = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= SCAN;
      col_r     <= 2'd0;
      dwell_r   <= {DW_W{1'b0}};
      db_r      <= {DB_W{1'b0}};
      pat_r     <= ROWS_IDLE;
      code_r    <= {KEY_W{1'b0}};
      held_r    <= 1'b0;
      valid_r   <= 1'b0;
      col_out_r <= 4'b1110;
    end else begin
      state_r   <= state_nxt_s;
      col_r     <= col_nxt_s;
      dwell_r   <= dwell_nxt_s;
      db_r      <= db_nxt_s;
      pat_r     <= pat_nxt_s;
      code_r    <= code_nxt_s;
      held_r    <= held_nxt_s;
      valid_r   <= fire_s;
      col_out_r <= ~(4'b0001 << col_nxt_s);
    end
  end

  assign col_out   = col_out_r;
  assign key_valid = valid_r;
  assign key_code  = code_r;
  assign key_held  = held_r;

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench for keypad_scan driven through a physical 4x4 key-matrix model.
module tb_keypad_scan;

  logic        clk;
  logic        rst;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;

  logic [15:0] pressed;
  logic [3:0]  exp_q[$];
  logic [3:0]  exp_code = 4'h0;
  logic [3:0]  exp_col;
  int          total = 0;
  int          bad   = 0;
  int          n;
  int          rb_len[4] = '{5, 2, 5, 4};

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key matrix: a closed key at (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_held(input logic lvl, input int budget, input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (key_held !== lvl && k < budget);
    check(name, {31'd0, key_held}, {31'd0, lvl});
  endtask

  // Monitor: pops the expected code on every strobe, otherwise key_code must hold.
  always @(posedge clk) begin : monitor
    logic r;
    r = rst;
    #1;
    if (r) begin
      exp_code = 4'h0;
    end else if (key_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL strobe_unexpected: actual code=%0h required=no strobe", key_code);
      end else begin
        exp_code = exp_q.pop_front();
        check("strobe_code", {28'd0, key_code}, {28'd0, exp_code});
        check("strobe_held", {31'd0, key_held}, 32'd1);
      end
    end else begin
      check("code_stable", {28'd0, key_code}, {28'd0, exp_code});
    end
  end

  initial begin
    rst = 1'b1;
    pressed = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_col_out", {28'd0, col_out}, 32'h0000000E);
    check("rst_valid", {31'd0, key_valid}, 32'd0);
    check("rst_code", {28'd0, key_code}, 32'd0);
    check("rst_held", {31'd0, key_held}, 32'd0);

    // Idle scan: each column driven for 4 cycles.
    for (int i = 0; i < 32; i++) begin
      if (i > 0) @(negedge clk);
      exp_col = 4'b0001 << ((i / 4) % 4);
      exp_col = ~exp_col;
      check("idle_col_out", {28'd0, col_out}, {28'd0, exp_col});
    end

    // Row2/col1 held 40 cycles then released.
    pressed[9] = 1'b1;
    exp_q.push_back(4'd9);
    repeat (40) @(negedge clk);
    check("press_held", {31'd0, key_held}, 32'd1);
    pressed[9] = 1'b0;
    repeat (10) @(negedge clk);
    check("release_held_still", {31'd0, key_held}, 32'd1);
    @(negedge clk);
    check("release_held_clear", {31'd0, key_held}, 32'd0);
    check("release_col0", {28'd0, col_out}, 32'h0000000E);

    // Bounce on row0/col3 inside the col3 debounce window.
    n = 0;
    while (col_out !== 4'b0111 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("align_col3", {28'd0, col_out}, 32'h00000007);
    pressed[3] = 1'b1;
    exp_q.push_back(4'd3);
    repeat (5) @(negedge clk);
    pressed[3] = 1'b0;
    @(negedge clk);
    pressed[3] = 1'b1;
    repeat (25) @(negedge clk);
    check("bounce_not_early", {31'd0, key_valid}, 32'd0);
    @(negedge clk);
    check("bounce_strobe_time", {31'd0, key_valid}, 32'd1);
    repeat (14) @(negedge clk);
    pressed[3] = 1'b0;
    wait_held(1'b0, 40, "bounce_release");

    // Rows 1 and 3 together in col0, then a second key while pressed.
    pressed[4]  = 1'b1;
    pressed[12] = 1'b1;
    exp_q.push_back(4'd4);
    repeat (11) @(negedge clk);
    check("multi_not_early", {31'd0, key_valid}, 32'd0);
    @(negedge clk);
    check("multi_strobe_time", {31'd0, key_valid}, 32'd1);
    pressed[8] = 1'b1;
    repeat (15) @(negedge clk);
    check("second_key_held", {31'd0, key_held}, 32'd1);
    pressed = 16'h0000;
    wait_held(1'b0, 40, "multi_release");
    check("multi_rescan_col0", {28'd0, col_out}, 32'h0000000E);

    // Release bounce on row3/col2: open 5, closed 2, open 5, closed 4.
    pressed[14] = 1'b1;
    exp_q.push_back(4'd14);
    wait_held(1'b1, 60, "rb_press");
    repeat (3) @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      pressed[14] = (p % 2 == 1);
      for (int k = 0; k < rb_len[p]; k++) begin
        @(negedge clk);
        check("rb_held", {31'd0, key_held}, 32'd1);
      end
    end
    pressed[14] = 1'b0;
    wait_held(1'b0, 40, "rb_release");

    // Reset while the debounce counter sits at 6.
    pressed[4] = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    pressed = 16'h0000;
    @(negedge clk);
    check("abort_col_out", {28'd0, col_out}, 32'h0000000E);
    check("abort_valid", {31'd0, key_valid}, 32'd0);
    check("abort_code", {28'd0, key_code}, 32'd0);
    check("abort_held", {31'd0, key_held}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_rescan_col1", {28'd0, col_out}, 32'h0000000D);

    repeat (40) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

endmodule
